host_mmio_if: RTL and testbench

- Parametrised host-communication block that sits beside the core's data-memory port in the simulation top.
- Replaces the single combinational tohost address match.
- Decodes NUM_CH consecutive tohost word addresses and queues every core store to them, tagged with its channel, in a FIFO. The bench drains the FIFO over a valid/ready handshake.
- Also provides a fromhost mailbox register that the host writes and the core reads or clears.

---
 rtl/host_mmio_pkg.sv | 28 ++
 rtl/host_fifo.sv | 52 +++++
 rtl/host_mmio_if.sv | 105 ++++++++++
 tb/tb_host_mmio_if.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/host_mmio_pkg.sv
// Shared constants, entry type and address decode helper for host_mmio_if.
// addr_to_ch turns an offset from the tohost base into {hit, channel}.
package host_mmio_pkg;

  localparam logic [31:0] TOHOST_BASE_DEF   = 32'h8000_1000;
  localparam logic [31:0] FROMHOST_ADDR_DEF = 32'h8000_1040;

  localparam int CH_W_MAX   = 4;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic [CH_W_MAX-1:0]   ch;
    logic [DATA_W_DEF-1:0] data;
  } th_entry_t;

  // Hit when word aligned and inside the channel window. The offset
  // is unsigned, so addresses below the base wrap high and miss.
  function automatic logic [CH_W_MAX:0] addr_to_ch(
    input logic [63:0] off,
    input logic [1:0]  lsb,
    input int unsigned num_ch
  );
    logic hit;
    hit = (lsb == 2'b00) && (off < 64'(4 * num_ch));
    return {hit, off[CH_W_MAX+1:2]};
  endfunction

endpackage

// File: rtl/host_fifo.sv
// Synchronous FIFO: push/pop, full/empty, occupancy count.
// Ports: clk, rst, push, pop, din, dout (0 when empty), full, empty, count.
module host_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign count   = cnt;
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/host_mmio_if.sv
// Host channel block: queues core stores to tohost channels in a FIFO
// and provides a fromhost mailbox the host writes and the core reads.
module host_mmio_if
  import host_mmio_pkg::*;
#(
  parameter int                DATA_W        = 32,
  parameter int                ADDR_W        = 32,
  parameter int                NUM_CH        = 4,
  parameter logic [ADDR_W-1:0] TOHOST_BASE   = TOHOST_BASE_DEF,
  parameter logic [ADDR_W-1:0] FROMHOST_ADDR = FROMHOST_ADDR_DEF,
  parameter int                DEPTH         = 8,
  localparam int               CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int               CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dm_wen_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_din_i,
  output logic              rd_hit_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              th_valid_o,
  output logic [CH_W-1:0]   th_ch_o,
  output logic [DATA_W-1:0] th_data_o,
  input  logic              th_ready_i,
  output logic [CNT_W-1:0]  th_count_o,
  output logic              overflow_o,
  input  logic              ovf_clr_i,
  input  logic              fh_wen_i,
  input  logic [DATA_W-1:0] fh_data_i,
  output logic              fh_pending_o
);

  localparam int E_W = CH_W + DATA_W;

  logic [ADDR_W-1:0]   off;
  logic [CH_W_MAX:0]   dec;
  logic                th_hit;
  logic                fh_sel;
  logic                full;
  logic                empty;
  logic                pop_eff;
  logic                drop;
  logic [E_W-1:0]      head;
  logic [DATA_W-1:0]   mbox;
  logic [DATA_W-1:0]   mbox_nxt;

  assign off    = dm_addr_i - TOHOST_BASE;
  assign dec    = addr_to_ch(64'(off), dm_addr_i[1:0],
                             NUM_CH[31:0]);
  assign th_hit = dm_wen_i & dec[CH_W_MAX];
  assign fh_sel = (dm_addr_i == FROMHOST_ADDR);

  if (CH_W < CH_W_MAX) begin : g_ch_hi
    logic unused_ch_hi;
    assign unused_ch_hi = ^dec[CH_W_MAX-1:CH_W];
  end

  assign th_valid_o = ~empty;
  assign pop_eff    = ~empty & th_ready_i;
  assign drop       = th_hit & full & ~pop_eff;
  assign th_ch_o    = head[E_W-1:DATA_W];
  assign th_data_o  = head[DATA_W-1:0];

  host_fifo #(
    .W     (E_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (th_hit),
    .pop   (th_ready_i),
    .din   ({dec[CH_W-1:0], dm_din_i}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (th_count_o)
  );

  // Host write has priority over a core store in the same cycle.
  always_comb begin
    mbox_nxt = mbox;
    if (fh_wen_i)                mbox_nxt = fh_data_i;
    else if (dm_wen_i && fh_sel) mbox_nxt = dm_din_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o   <= 1'b0;
      mbox         <= '0;
      fh_pending_o <= 1'b0;
      rd_hit_o     <= 1'b0;
      rd_data_o    <= '0;
    end else begin
      if (drop)           overflow_o <= 1'b1;
      else if (ovf_clr_i) overflow_o <= 1'b0;
      mbox         <= mbox_nxt;
      fh_pending_o <= (mbox_nxt != '0);
      // Read returns the mailbox as it was before this edge's writes.
      rd_hit_o     <= ~dm_wen_i & fh_sel;
      rd_data_o    <= (~dm_wen_i & fh_sel) ? mbox : '0;
    end
  end

endmodule

// File: tb/tb_host_mmio_if.sv
// Bench for host_mmio_if: queue-based model checked every cycle,
// plus directed literal checks.
module tb_host_mmio_if;

  localparam logic [31:0] BASE = 32'h8000_1000;
  localparam logic [31:0] FH   = 32'h8000_1040;
  localparam int          DEP  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dm_wen = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_din = '0;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic        th_valid;
  logic [1:0]  th_ch;
  logic [31:0] th_data;
  logic        th_ready = 1'b0;
  logic [3:0]  th_count;
  logic        overflow;
  logic        ovf_clr = 1'b0;
  logic        fh_wen = 1'b0;
  logic [31:0] fh_data = '0;
  logic        fh_pending;

  int total = 0;
  int bad = 0;

  host_mmio_if dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .dm_wen_i     (dm_wen),
    .dm_addr_i    (dm_addr),
    .dm_din_i     (dm_din),
    .rd_hit_o     (rd_hit),
    .rd_data_o    (rd_data),
    .th_valid_o   (th_valid),
    .th_ch_o      (th_ch),
    .th_data_o    (th_data),
    .th_ready_i   (th_ready),
    .th_count_o   (th_count),
    .overflow_o   (overflow),
    .ovf_clr_i    (ovf_clr),
    .fh_wen_i     (fh_wen),
    .fh_data_i    (fh_data),
    .fh_pending_o (fh_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_mbox = '0;
  logic        m_rd_hit = 1'b0;
  logic [31:0] m_rd_data = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: spec rules on a queue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_mbox = '0;
      m_rd_hit = 1'b0;
      m_rd_data = '0;
    end else begin
      logic [31:0] off;
      logic        hit;
      logic        popped;
      logic        dropped;
      ent_t        e;
      off = dm_addr - BASE;
      hit = dm_wen && dm_addr[1:0] == 2'b00 && off < 32'd16;
      popped = th_ready && q.size() > 0;
      if (popped) void'(q.pop_front());
      dropped = 1'b0;
      if (hit) begin
        if (q.size() < DEP) begin
          e.ch = off[3:2];
          e.d  = dm_din;
          q.push_back(e);
        end else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_rd_hit  = !dm_wen && dm_addr == FH;
      m_rd_data = m_rd_hit ? m_mbox : 32'd0;
      if (fh_wen) m_mbox = fh_data;
      else if (dm_wen && dm_addr == FH) m_mbox = dm_din;
    end
  end

  always @(negedge clk) begin
    chk("valid", 64'(th_valid), 64'(q.size() != 0));
    chk("count", 64'(th_count), 64'(q.size()));
    chk("ch", 64'(th_ch), q.size() != 0 ? 64'(q[0].ch) : 64'd0);
    chk("data", 64'(th_data), q.size() != 0 ? 64'(q[0].d) : 64'd0);
    chk("ovf", 64'(overflow), 64'(m_ovf));
    chk("pending", 64'(fh_pending), 64'(m_mbox != 0));
    chk("rd_hit", 64'(rd_hit), 64'(m_rd_hit));
    chk("rd_data", 64'(rd_data), 64'(m_rd_data));
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    dm_wen = 1'b1;
    dm_addr = a;
    dm_din = d;
    cyc();
    dm_wen = 1'b0;
    dm_addr = '0;
    dm_din = '0;
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_valid", 64'(th_valid), 64'd0);
    chk("rst_count", 64'(th_count), 64'd0);
    rst = 1'b0;
    cyc();

    store(32'h8000_1008, 32'hDEAD_BEEF);
    chk("t1_valid", 64'(th_valid), 64'd1);
    chk("t1_ch", 64'(th_ch), 64'd2);
    chk("t1_data", 64'(th_data), 64'hDEAD_BEEF);
    chk("t1_count", 64'(th_count), 64'd1);
    th_ready = 1'b1;
    cyc();
    th_ready = 1'b0;
    chk("t1_pop", 64'(th_count), 64'd0);

    for (int i = 0; i < 9; i++)
      store(BASE + 32'(4 * (i % 4)), 32'(100 + i));
    chk("t2_count", 64'(th_count), 64'd8);
    chk("t2_ovf", 64'(overflow), 64'd1);
    th_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_order", 64'(th_data), 64'(100 + i));
      cyc();
    end
    th_ready = 1'b0;
    chk("t2_empty", 64'(th_valid), 64'd0);
    chk("t2_ovf_hold", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("t2_ovf_clr", 64'(overflow), 64'd0);

    for (int i = 0; i < 8; i++)
      store(BASE + 32'(4 * (i % 4)), 32'(200 + i));
    th_ready = 1'b1;
    store(BASE + 32'd4, 32'h300);
    th_ready = 1'b0;
    chk("t3_count", 64'(th_count), 64'd8);
    chk("t3_ovf", 64'(overflow), 64'd0);
    th_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_order", 64'(th_data), i < 7 ? 64'(201 + i) : 64'h300);
      cyc();
    end
    th_ready = 1'b0;

    store(32'h8000_1010, 32'h11);
    store(32'h8000_1002, 32'h22);
    dm_addr = BASE;
    cyc();
    dm_addr = '0;
    chk("t4_nopush", 64'(th_count), 64'd0);

    fh_wen = 1'b1;
    fh_data = 32'h5;
    cyc();
    fh_wen = 1'b0;
    chk("t5_pend", 64'(fh_pending), 64'd1);
    dm_addr = FH;
    cyc();
    dm_addr = '0;
    chk("t5_rd_hit", 64'(rd_hit), 64'd1);
    chk("t5_rd_data", 64'(rd_data), 64'd5);
    store(FH, 32'h0);
    chk("t5_core_clr", 64'(fh_pending), 64'd0);
    fh_wen = 1'b1;
    fh_data = 32'h7;
    store(FH, 32'h0);
    fh_wen = 1'b0;
    chk("t5_prio", 64'(fh_pending), 64'd1);
    dm_addr = FH;
    cyc();
    dm_addr = '0;
    chk("t5_rd7", 64'(rd_data), 64'd7);
    cyc();
    chk("t5_rd_idle", 64'(rd_hit), 64'd0);

    for (int i = 0; i < 9; i++)
      store(BASE + 32'(4 * (i % 4)), 32'(400 + i));
    th_ready = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    chk("t6_three", 64'(th_count), 64'd3);
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(th_valid), 64'd0);
    chk("t6_count", 64'(th_count), 64'd0);
    chk("t6_ovf", 64'(overflow), 64'd0);
    chk("t6_pend", 64'(fh_pending), 64'd0);
    th_ready = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
